// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver family.
// Holds the FSM state encoding, the parity modes and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Expected parity bit for up to 9 data bits; unused upper bits must be zero.
    function automatic logic parity_calc(input logic [8:0] data, input int mode);
        logic p;
        p = 1'b0;
        if (mode == PAR_EVEN) begin
            p = ^data;
        end else if (mode == PAR_ODD) begin
            p = ~^data;
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for the asynchronous rx line; latency STAGES clocks.
// Flops reset to 1 so an idle line never looks like a start bit after reset.
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver; frame appears on the outputs one clk after the last stop sample.
// 1-deep output register with valid/ready; a frame arriving while it is full is dropped and flagged.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int OS_RATE     = 16,
    parameter int PARITY      = 1,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic              os_tick,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              p_error,
    output logic              stop_error,
    output logic              break_det,
    output logic              overrun,
    output logic              busy
);

    localparam int TW = $clog2(OS_RATE);
    localparam int BW = $clog2(DATA_W);

    localparam logic [TW-1:0] TICK_HALF = TW'(OS_RATE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OS_RATE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    logic rxs;

    uart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rxs)
    );

    state_t            state_q, state_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              zero_q, zero_d;

    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_q, valid_d;
    logic              perr_out_q, perr_out_d;
    logic              ferr_out_q, ferr_out_d;
    logic              brk_q, brk_d;
    logic              ovr_q, ovr_d;
    logic              busy_q, busy_d;

    logic [8:0]        data_ext;
    logic              commit;
    logic              accept;

    always_comb begin
        data_ext                = '0;
        data_ext[DATA_W-1:0]    = shift_q;
    end

    // Frame FSM and counters; every state change happens on an os_tick.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        zero_d  = zero_q;
        commit  = 1'b0;

        if (os_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rxs) begin
                        state_d = S_START;
                        tick_d  = '0;
                    end
                end
                S_START: begin
                    if (tick_q == TICK_HALF) begin
                        if (rxs) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                            perr_d  = 1'b0;
                            ferr_d  = 1'b0;
                            zero_d  = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                S_DATA: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        shift_d = {rxs, shift_q[DATA_W-1:1]};
                        zero_d  = zero_q & ~rxs;
                        if (bit_q == BIT_LAST) begin
                            bit_d   = '0;
                            state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                S_PARITY: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        zero_d  = zero_q & ~rxs;
                        perr_d  = (rxs != parity_calc(data_ext, PARITY));
                        state_d = S_STOP;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                S_STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        zero_d = zero_q & ~rxs;
                        ferr_d = ferr_q | ~rxs;
                        if (bit_q == STOP_LAST) begin
                            bit_d   = '0;
                            state_d = S_IDLE;
                            commit  = 1'b1;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            endcase
        end
    end

    // Output buffer: a commit may reload the register in the same clk it is drained.
    always_comb begin
        accept     = valid_q & rx_ready;
        valid_d    = valid_q & ~accept;
        data_out_d = data_out_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        ovr_d      = accept ? 1'b0 : ovr_q;
        brk_d      = 1'b0;
        busy_d     = (state_d != S_IDLE);

        if (commit) begin
            brk_d = zero_d;
            if (!valid_q || accept) begin
                valid_d    = 1'b1;
                data_out_d = shift_d;
                perr_out_d = perr_d;
                ferr_out_d = ferr_d;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            zero_q     <= 1'b0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            brk_q      <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            zero_q     <= zero_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            brk_q      <= brk_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
        end
    end

    assign rx_data    = data_out_q;
    assign rx_valid   = valid_q;
    assign p_error    = perr_out_q;
    assign stop_error = ferr_out_q;
    assign break_det  = brk_q;
    assign overrun    = ovr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: even-parity DUT plus an odd-parity twin on the same line.
// os_tick pulses every second clk, so one bit period is 32 clks.
module tb_uart_rx_os;

    localparam int DATA_W   = 8;
    localparam int OS_RATE  = 16;
    localparam int BIT_CLKS = 2 * OS_RATE;

    logic              clk      = 1'b0;
    logic              reset    = 1'b0;
    logic              rx       = 1'b1;
    logic              rx_ready = 1'b0;
    logic              tick_ph  = 1'b0;
    logic              os_tick;

    logic [DATA_W-1:0] rx_data;
    logic              rx_valid, p_error, stop_error, break_det, overrun, busy;

    logic              odd_ready = 1'b1;
    logic [DATA_W-1:0] odd_data;
    logic              odd_valid, odd_perr, odd_ferr, odd_brk, odd_ovr, odd_busy;

    always #5 clk = ~clk;
    always @(posedge clk) tick_ph <= ~tick_ph;
    assign os_tick = tick_ph;

    uart_rx_os #(
        .DATA_W(DATA_W), .OS_RATE(OS_RATE), .PARITY(1), .STOP_BITS(1), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx), .os_tick(os_tick),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .p_error(p_error), .stop_error(stop_error), .break_det(break_det),
        .overrun(overrun), .busy(busy)
    );

    uart_rx_os #(
        .DATA_W(DATA_W), .OS_RATE(OS_RATE), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)
    ) dut_odd (
        .clk(clk), .reset(reset), .rx(rx), .os_tick(os_tick),
        .rx_data(odd_data), .rx_valid(odd_valid), .rx_ready(odd_ready),
        .p_error(odd_perr), .stop_error(odd_ferr), .break_det(odd_brk),
        .overrun(odd_ovr), .busy(odd_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Capture every handshake and count break pulses, sampled mid-cycle.
    int                n_frames = 0;
    int                n_odd    = 0;
    int                n_brk    = 0;
    logic [DATA_W-1:0] cap_data = '0;
    logic              cap_perr = 1'b0;
    logic              cap_ferr = 1'b0;
    logic              cap_odd_perr = 1'b1;

    always @(negedge clk) begin
        if (rx_valid && rx_ready) begin
            n_frames++;
            cap_data = rx_data;
            cap_perr = p_error;
            cap_ferr = stop_error;
        end
        if (odd_valid && odd_ready) begin
            n_odd++;
            cap_odd_perr = odd_perr;
        end
        if (break_det) n_brk++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stp);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int brk0;

    initial begin
        wait_clks(3);
        @(negedge clk);
        check("rst_valid",   rx_valid,   0);
        check("rst_data",    rx_data,    0);
        check("rst_perr",    p_error,    0);
        check("rst_ferr",    stop_error, 0);
        check("rst_break",   break_det,  0);
        check("rst_overrun", overrun,    0);
        check("rst_busy",    busy,       0);
        wait_clks(1);
        reset    = 1'b1;
        rx_ready = 1'b1;
        wait_clks(4);

        // 1: clean 0xA5, even parity bit 0
        send_frame(8'hA5, 1'b0, 1'b1);
        send_bit(1'b1);
        @(negedge clk);
        check("t1_frames", n_frames, 1);
        check("t1_data",   cap_data, 8'hA5);
        check("t1_perr",   cap_perr, 0);
        check("t1_ferr",   cap_ferr, 0);
        check("t1_valid_drained", rx_valid, 0);
        wait_clks(1);

        // 2: 0x3C with parity bit 1 -> even mismatch, odd match
        send_frame(8'h3C, 1'b1, 1'b1);
        send_bit(1'b1);
        @(negedge clk);
        check("t2_frames",   n_frames, 2);
        check("t2_data",     cap_data, 8'h3C);
        check("t2_perr_even", cap_perr, 1);
        check("t2_odd_frames", n_odd, 2);
        check("t2_perr_odd", cap_odd_perr, 0);
        wait_clks(1);

        // 3: false start, 6 ticks low
        rx = 1'b0;
        wait_clks(8);
        @(negedge clk);
        check("t3_busy_start", busy, 1);
        wait_clks(3);
        rx = 1'b1;
        wait_clks(40);
        @(negedge clk);
        check("t3_busy_idle", busy, 0);
        check("t3_no_valid",  rx_valid, 0);
        check("t3_frames",    n_frames, 2);
        wait_clks(1);

        // 4: break, line low for 11 bit times
        brk0 = n_brk;
        for (int i = 0; i < 11; i++) send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        @(negedge clk);
        check("t4_frames", n_frames, 3);
        check("t4_data",   cap_data, 8'h00);
        check("t4_ferr",   cap_ferr, 1);
        check("t4_perr",   cap_perr, 0);
        check("t4_break_pulses", n_brk - brk0, 1);
        check("t4_busy",   busy, 0);
        wait_clks(1);

        // 5: overrun with consumer stalled, back-to-back frames
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        send_bit(1'b1);
        @(negedge clk);
        check("t5_valid",   rx_valid, 1);
        check("t5_data",    rx_data,  8'h11);
        check("t5_overrun", overrun,  1);
        check("t5_frames",  n_frames, 3);
        wait_clks(1);
        rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5_valid_drop",  rx_valid, 0);
        check("t5_overrun_clr", overrun,  0);
        check("t5_frames_acc",  n_frames, 4);
        check("t5_acc_data",    cap_data, 8'h11);
        wait_clks(1);

        // 6: reset in the middle of 0x5A data bits
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk);
        check("t6_busy_mid", busy, 1);
        wait_clks(1);
        reset = 1'b0;
        rx    = 1'b1;
        #1;
        check("t6_rst_busy",  busy,     0);
        check("t6_rst_valid", rx_valid, 0);
        check("t6_rst_data",  rx_data,  0);
        wait_clks(3);
        reset = 1'b1;
        wait_clks(2 * BIT_CLKS);
        @(negedge clk);
        check("t6_no_partial", n_frames, 4);
        check("t6_valid_idle", rx_valid, 0);
        wait_clks(1);
        send_frame(8'h5A, 1'b0, 1'b1);
        send_bit(1'b1);
        @(negedge clk);
        check("t6_frames", n_frames, 5);
        check("t6_data",   cap_data, 8'h5A);
        check("t6_perr",   cap_perr, 0);
        check("t6_ferr",   cap_ferr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
